fifo_rd_stream_adapter: RTL and testbench
=========================================

Name: fifo_rd_stream_adapter

Overview:
- Read-side companion for the team's synchronous FIFO.
- Drives the FIFO's read_en/empty/data_out port, absorbs its 1-cycle registered read latency, and presents the words as a valid/ready stream to a downstream consumer.
- A 2-entry internal skid buffer sustains 1 word/cycle under continuous m_ready. Includes flush and a delivered-word counter.

Parameters:
- N, 4: data width; must equal the FIFO's N.
- CW, 16: width of the delivered-word counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- fifo_empty  in  1  FIFO empty flag.
- fifo_data_out  in  N  FIFO registered read data; valid the cycle after a read is accepted.
- fifo_read_en  out  1  read request to the FIFO.
- m_valid  out  1  stream data valid.
- m_data  out  N  stream data, FIFO order.
- m_ready  in  1  consumer ready.
- flush  in  1  discard all buffered and in-flight words.
- word_cnt  out  CW  count of words delivered (m_valid && m_ready); wraps modulo 2^CW.

Behaviour:
- Reset (reset==0 at a clk edge): occ=0, inflight=0, m_valid=0, m_data=0, word_cnt=0. fifo_read_en is combinational and is 0 while reset is asserted. Reset overrides flush and all traffic.
- State:
  - occ: number of held entries, 0..2.
  - inflight: 1 if a read was issued last cycle.
  - buffer: 2 regs, head = oldest.
- pop = m_valid && m_ready. m_valid = (occ != 0). m_data = head entry, registered.
- Read issue (combinational): fifo_read_en = reset && !flush && !fifo_empty && ((occ + inflight - pop) < 2).
  - This creates a comb path from m_ready to fifo_read_en; the path is intentional.
- inflight <= fifo_read_en.
- When inflight==1, capture fifo_data_out at the edge into the tail slot (after the pop shift).
  - Overflow is impossible by construction; flag it with an assertion.
- Simultaneous pop and capture in the same cycle: occ is unchanged; the head advances and the new word enters the tail.
- Latency:
  - Empty adapter, word present: fifo_read_en in cycle 0, data on fifo_data_out in cycle 1, m_valid=1 in cycle 2.
  - Steady state with m_ready held at 1: 1 word/cycle, no bubbles.
- Backpressure (m_ready=0):
  - m_data and m_valid hold stable while m_valid=1.
  - Reads stop once occ + inflight == 2; no word is lost or duplicated.
- fifo_empty rises mid-stream: no further reads. Buffered words still drain; m_valid drops when occ reaches 0.
- flush=1 (synchronous, one or more cycles):
  - Next edge: occ=0, m_valid=0.
  - Any word arriving from an in-flight read in that cycle is discarded.
  - No read is issued while flush=1.
  - A pop coincident with flush still counts in word_cnt (consumer saw the handshake).
  - The FIFO itself is not flushed; words remaining in it are read normally after flush deasserts.
- word_cnt increments by 1 on every pop; wraps from 2^CW-1 to 0.

Decomposition:
- Shared package fifo_pkg: default N, CW, skid depth constant SKID_DEPTH=2.
- One natural sub-module: skid_buf2 (2-entry register buffer with push/pop/clear and occ output).
- Top level holds the read-issue logic, inflight tracking, and word_cnt.

Test Plan:
- Reset: hold reset=0 for 2 cycles with fifo_empty=0, m_ready=1 -> fifo_read_en=0, m_valid=0, word_cnt=0. Release -> fifo_read_en=1 on the first cycle after release.
- Streaming: FIFO preloaded with 0x1..0x8, m_ready=1 -> m_data sequence 1..8 on consecutive cycles starting 2 cycles after the first read; word_cnt=8; then m_valid=0.
- Backpressure: FIFO holds 0xA,0xB,0xC,0xD; m_ready=0 for 10 cycles -> exactly 2 reads issued, m_data=0xA stable. Then m_ready=1 -> A,B,C,D delivered in order with no duplicates.
- Empty boundary: FIFO has 1 word 0x5 -> single read, m_valid=1 for one cycle with m_ready=1, then fifo_read_en stays 0 while fifo_empty=1.
- Flush mid-stream: FIFO 0x1..0x6, m_ready=0 until occ=2. Pulse flush 1 cycle with a read in flight -> m_valid=0 next cycle and the in-flight word is dropped. Then m_ready=1 -> the stream resumes with the next un-read FIFO word.
- Counter wrap: with CW=4, deliver 17 words -> word_cnt=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side stream adapter.
// Defaults track the team's synchronous FIFO data width.
package fifo_pkg;

  localparam int N_DEF      = 4;
  localparam int CW_DEF     = 16;
  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  localparam occ_t SKID_FULL = occ_t'(SKID_DEPTH);

endpackage

// File: rtl/fifo_rd_stream_adapter_skid_buf2.sv
// Two-entry register buffer; pop shifts the head out before
// a push lands in the first free slot.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] din,
  output occ_t         occ,
  output logic [N-1:0] head
);

  occ_t         occ_q, occ_d, occ_pop;
  logic [N-1:0] e0_q, e0_d;
  logic [N-1:0] e1_q, e1_d;
  logic         pop_ok;

  always_comb begin
    pop_ok  = pop && (occ_q != 2'd0);
    occ_pop = occ_q - {1'b0, pop_ok};
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (pop_ok)
      e0_d = e1_q;
    if (push) begin
      if (occ_pop == 2'd0)
        e0_d = din;
      else
        e1_d = din;
    end
    occ_d = occ_pop + {1'b0, push};
    if (clear)
      occ_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      occ_q <= occ_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  // read issue is throttled on occ+inflight, so a third word never arrives
  always_ff @(posedge clk) begin
    if (reset)
      assert (!(push && occ_pop == SKID_FULL));
  end

  assign occ  = occ_q;
  assign head = e0_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Reads the synchronous FIFO, hides its one-cycle read latency
// and presents the words as a valid/ready stream.
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fifo_empty,
  input  logic [N-1:0]  fifo_data_out,
  output logic          fifo_read_en,
  output logic          m_valid,
  output logic [N-1:0]  m_data,
  input  logic          m_ready,
  input  logic          flush,
  output logic [CW-1:0] word_cnt
);

  occ_t          occ;
  logic          pop;
  logic          push;
  logic [2:0]    pend;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;

  // m_ready reaches fifo_read_en combinationally so a pop frees a slot now
  always_comb begin
    pend = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    fifo_read_en = reset && !flush && !fifo_empty
                   && (pend < 3'd2);
    push       = inflight_q && !flush;
    inflight_d = fifo_read_en;
    word_cnt_d = word_cnt_q + CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  skid_buf2 #(
    .N (N)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .din   (fifo_data_out),
    .occ   (occ),
    .head  (m_data)
  );

  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter with a small
// registered-read FIFO model in front of it.
module tb_fifo_rd_stream_adapter;

  localparam int N  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fifo_empty;
  logic [N-1:0]  fifo_data_out;
  logic          fifo_read_en;
  logic          m_valid;
  logic [N-1:0]  m_data;
  logic          m_ready = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] word_cnt;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] mem [64];
  int           wr_ptr = 0;
  int           rd_ptr;
  int           rd_cnt;
  logic [N-1:0] rx [64];
  int           rx_n;

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(
    .N  (N),
    .CW (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_read_en  (fifo_read_en),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .flush         (flush),
    .word_cnt      (word_cnt)
  );

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (!reset) begin
      rd_ptr        <= 0;
      fifo_data_out <= '0;
      rd_cnt        <= 0;
      rx_n          <= 0;
    end else begin
      if (fifo_read_en) begin
        fifo_data_out <= mem[rd_ptr % 64];
        rd_ptr        <= rd_ptr + 1;
        rd_cnt        <= rd_cnt + 1;
      end
      if (m_valid && m_ready && rx_n < 64) begin
        rx[rx_n] <= m_data;
        rx_n     <= rx_n + 1;
      end
    end
  end

  task automatic push_word(input logic [N-1:0] v);
    mem[wr_ptr % 64] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    wr_ptr  = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    wr_ptr  = 0;
    push_word(4'h9);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (fifo_read_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_rd_en cyc%0d got %b exp 0", c, fifo_read_en);
      end
      checks++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_m_valid cyc%0d got %b exp 0", c, m_valid);
      end
    end
    checks++;
    if (word_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_word_cnt got %0d exp 0", word_cnt);
    end
    checks++;
    if (m_data !== 4'h0) begin
      errors++;
      $display("FAIL reset_m_data got %h exp 0", m_data);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (fifo_read_en !== 1'b1) begin
      errors++;
      $display("FAIL release_rd_en got %b exp 1", fifo_read_en);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_streaming();
    do_reset();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(4'(i));
    #1;
    checks++;
    if (fifo_read_en !== 1'b1) begin
      errors++;
      $display("FAIL stream_first_rd got %b exp 1", fifo_read_en);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_lat_c1 got %b exp 0", m_valid);
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 4'(i)) begin
        errors++;
        $display("FAIL stream_word%0d got v=%b d=%h exp v=1 d=%h",
                 i, m_valid, m_data, 4'(i));
      end
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_done_valid got %b exp 0", m_valid);
    end
    checks++;
    if (word_cnt !== 4'd8 || rd_cnt !== 8) begin
      errors++;
      $display("FAIL stream_counts got cnt=%0d rd=%0d exp cnt=8 rd=8",
               word_cnt, rd_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] exp_w [4];
    exp_w = '{4'hA, 4'hB, 4'hC, 4'hD};
    do_reset();
    for (int i = 0; i < 4; i++) push_word(exp_w[i]);
    repeat (10) @(negedge clk);
    checks++;
    if (rd_cnt !== 2) begin
      errors++;
      $display("FAIL bp_reads got %0d exp 2", rd_cnt);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 4'hA || fifo_read_en !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got v=%b d=%h rd=%b exp v=1 d=a rd=0",
               m_valid, m_data, fifo_read_en);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_w[k]) begin
        errors++;
        $display("FAIL bp_drain%0d got v=%b d=%h exp v=1 d=%h",
                 k, m_valid, m_data, exp_w[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (m_valid !== 1'b0 || word_cnt !== 4'd4 || rd_cnt !== 4) begin
      errors++;
      $display("FAIL bp_end got v=%b cnt=%0d rd=%0d exp v=0 cnt=4 rd=4",
               m_valid, word_cnt, rd_cnt);
    end
  endtask

  task automatic test_empty_boundary();
    do_reset();
    m_ready = 1'b1;
    push_word(4'h5);
    #1;
    checks++;
    if (fifo_read_en !== 1'b1) begin
      errors++;
      $display("FAIL empty_rd got %b exp 1", fifo_read_en);
    end
    @(negedge clk);
    checks++;
    if (fifo_read_en !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_c1 got rd=%b v=%b exp rd=0 v=0",
               fifo_read_en, m_valid);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 4'h5) begin
      errors++;
      $display("FAIL empty_word got v=%b d=%h exp v=1 d=5", m_valid, m_data);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || fifo_read_en !== 1'b0) begin
        errors++;
        $display("FAIL empty_idle%0d got v=%b rd=%b exp v=0 rd=0",
                 c, m_valid, fifo_read_en);
      end
    end
    checks++;
    if (rd_cnt !== 1 || word_cnt !== 4'd1) begin
      errors++;
      $display("FAIL empty_counts got rd=%0d cnt=%0d exp rd=1 cnt=1",
               rd_cnt, word_cnt);
    end
  endtask

  task automatic test_flush();
    logic [N-1:0] exp_w [5];
    exp_w = '{4'h1, 4'h2, 4'h4, 4'h5, 4'h6};
    do_reset();
    for (int i = 1; i <= 6; i++) push_word(4'(i));
    repeat (3) @(negedge clk);
    checks++;
    if (m_data !== 4'h1 || rd_cnt !== 2 || fifo_read_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_fill got d=%h rd=%0d en=%b exp d=1 rd=2 en=0",
               m_data, rd_cnt, fifo_read_en);
    end
    m_ready = 1'b1;
    #1;
    checks++;
    if (fifo_read_en !== 1'b1) begin
      errors++;
      $display("FAIL flush_pop_rd got %b exp 1", fifo_read_en);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 4'h2 || fifo_read_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle got v=%b d=%h en=%b exp v=1 d=2 en=0",
               m_valid, m_data, fifo_read_en);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || word_cnt !== 4'd2) begin
      errors++;
      $display("FAIL flush_after got v=%b cnt=%0d exp v=0 cnt=2",
               m_valid, word_cnt);
    end
    checks++;
    if (fifo_read_en !== 1'b1) begin
      errors++;
      $display("FAIL flush_resume_rd got %b exp 1", fifo_read_en);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || word_cnt !== 4'd5 || rx_n !== 5) begin
      errors++;
      $display("FAIL flush_end got v=%b cnt=%0d rx=%0d exp v=0 cnt=5 rx=5",
               m_valid, word_cnt, rx_n);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rx[k] !== exp_w[k]) begin
        errors++;
        $display("FAIL flush_seq%0d got %h exp %h", k, rx[k], exp_w[k]);
      end
    end
  endtask

  task automatic test_counter_wrap();
    int bad;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_word(4'(i + 3));
    repeat (22) @(negedge clk);
    checks++;
    if (word_cnt !== 4'd1 || rx_n !== 17) begin
      errors++;
      $display("FAIL wrap_cnt got cnt=%0d rx=%0d exp cnt=1 rx=17",
               word_cnt, rx_n);
    end
    bad = 0;
    for (int i = 0; i < 17; i++)
      if (rx[i] !== 4'(i + 3)) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL wrap_seq got %0d bad words exp 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_boundary();
    test_flush();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
